// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared requester IDs, arbiter states and reset constants for mem_arb.
package mem_arb_pkg;
    typedef enum logic {REQ_SCR = 1'b0, REQ_CPU = 1'b1} req_id_t;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} arb_state_t;
    localparam req_id_t LAST_RST = REQ_CPU;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: one memory port, made of an address-request channel and a read-data return
// channel that both use vld/gnt; master issues addresses and consumes data.
interface mem_arb_if #(parameter int AW = 20, parameter int DW = 16);
    logic          addr_vld;
    logic          addr_gnt;
    logic [AW-1:0] addr;
    logic          dat_vld;
    logic          dat_gnt;
    logic [DW-1:0] dat;
    modport master (output addr_vld, addr, dat_gnt, input addr_gnt, dat_vld, dat);
    modport slave  (input addr_vld, addr, dat_gnt, output addr_gnt, dat_vld, dat);
endinterface

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: in-order FIFO of requester IDs, one entry per outstanding read.
module mem_arb_tag_fifo import mem_arb_pkg::*; #(
    parameter int MAX_OUTST = 4
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    i_push,
    input  req_id_t i_push_id,
    input  logic    i_pop,
    output req_id_t o_head,
    output logic    o_full,
    output logic    o_empty
);
    localparam int PW = $clog2(MAX_OUTST);
    req_id_t       r_mem [MAX_OUTST];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_id;
    end
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_count == (PW+1)'(MAX_OUTST);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: screen/CPU arbiter for the external memory port, with in-order read-data routing.
// Define MEM_ARB_SCR_PRIO_EN to let the screen win every tie instead of round robin.
module mem_arb import mem_arb_pkg::*; #(
    parameter int AW        = 20,
    parameter int DW        = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic      clk,
    input  logic      rstn,
    mem_arb_if.slave  scr,
    mem_arb_if.slave  cpu,
    mem_arb_if.master mem,
    output logic      err_unexp
);
    arb_state_t    r_state;
    arb_state_t    w_next;
    req_id_t       r_lock_id;
    req_id_t       w_sel;
    req_id_t       w_tie;
    req_id_t       w_head;
    logic          w_sel_vld;
    logic          w_addr_vld;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          r_err_unexp;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_dat;
`ifdef MEM_ARB_SCR_PRIO_EN
    assign w_tie = REQ_SCR;
`else
    req_id_t r_last;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_last <= LAST_RST;
        else if (w_push) r_last <= w_sel;
    end
    assign w_tie = (r_last == REQ_CPU) ? REQ_SCR : REQ_CPU;
`endif
    // Once a request is pending, the selection stays frozen until it is taken.
    assign w_sel      = (r_state == LOCKED) ? r_lock_id :
                        (scr.addr_vld & cpu.addr_vld) ? w_tie :
                        cpu.addr_vld ? REQ_CPU : REQ_SCR;
    assign w_sel_vld  = (w_sel == REQ_SCR) ? scr.addr_vld : cpu.addr_vld;
    assign w_addr     = (w_sel == REQ_SCR) ? scr.addr : cpu.addr;
    assign w_addr_vld = rstn & w_sel_vld & !w_full;
    assign w_push     = w_addr_vld & mem.addr_gnt;
    assign w_pop      = mem.dat_vld & mem.dat_gnt & !w_empty;
    assign w_dat      = mem.dat;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= UNLOCKED;
            r_lock_id <= REQ_SCR;
        end else begin
            r_state   <= w_next;
            r_lock_id <= w_sel;
        end
    end
    always_comb begin
        w_next = (r_state == UNLOCKED) ? ((w_addr_vld & !mem.addr_gnt) ? LOCKED : UNLOCKED) :
                 ((w_push | !w_sel_vld) ? UNLOCKED : LOCKED);
    end
    always_comb begin
        mem.addr_vld = w_addr_vld;
        mem.addr     = w_addr;
        scr.addr_gnt = w_push & (w_sel == REQ_SCR);
        cpu.addr_gnt = w_push & (w_sel == REQ_CPU);
    end
    // With no tag outstanding, returned data is drained so the controller cannot hang.
    always_comb begin
        scr.dat_vld = rstn & mem.dat_vld & !w_empty & (w_head == REQ_SCR);
        cpu.dat_vld = rstn & mem.dat_vld & !w_empty & (w_head == REQ_CPU);
        scr.dat     = w_dat;
        cpu.dat     = w_dat;
        mem.dat_gnt = rstn & (w_empty | ((w_head == REQ_SCR) ? scr.dat_gnt : cpu.dat_gnt));
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_err_unexp <= 1'b0;
        else if (mem.dat_vld & w_empty) r_err_unexp <= 1'b1;
    end
    assign err_unexp = r_err_unexp;
    mem_arb_tag_fifo #(.MAX_OUTST(MAX_OUTST)) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_push    (w_push),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );
endmodule
